// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life update paths: board size defaults,
// controller state encoding and the next-state rule.
package gol_pkg;

  localparam int GOL_LOG_W = 6;
  localparam int GOL_LOG_H = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRIME   = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Row buffer targeted by a read; MID also fills the saved copy of row 0.
  localparam logic [1:0] SEL_TOP = 2'd0;
  localparam logic [1:0] SEL_MID = 2'd1;
  localparam logic [1:0] SEL_BOT = 2'd2;

  // win[4] is the centre; the other eight bits are its neighbours.
  function automatic logic gol_next(input logic [8:0] win);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i != 32'd4) n = n + {3'b000, win[i]};
    end
    return (n == 4'd3) | (win[4] & (n == 4'd2));
  endfunction

endpackage

// File: rtl/gol_cell_rule.sv
// Combinational Game of Life rule for one 3x3 window.
module gol_cell_rule
  import gol_pkg::*;
(
  input  logic [8:0] win_i,
  output logic       next_o
);

  assign next_o = gol_next(win_i);

endmodule

// File: rtl/gol_stream_engine.sv
// Three-row sliding-window next-state engine for a toroidal Life board.
// Reads the current board through a 1-cycle read port, writes every cell once in raster order.
module gol_stream_engine
  import gol_pkg::*;
#(
  parameter int LOG_W = GOL_LOG_W,
  parameter int LOG_H = GOL_LOG_H
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [LOG_W+LOG_H-1:0] rd_addr,
  input  logic                   rd_data,
  output logic                   wr_en,
  output logic [LOG_W+LOG_H-1:0] wr_addr,
  output logic                   wr_data
);

  localparam int AW = LOG_W + LOG_H;
  localparam int W  = 1 << LOG_W;
  localparam int KW = LOG_W + 2;

  logic [2:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [LOG_H-1:0] y_q, y_d, y_inc;
  logic [LOG_W-1:0] c_q;
  logic [W-1:0]     top_q, mid_q, bot_q, first_q;
  logic [W-1:0]     top_e, mid_e, bot_e, first_e;
  logic [W-1:0]     top_d, mid_d, bot_d, first_d;

  logic             cap_en_q;
  logic [1:0]       cap_sel_q;
  logic [LOG_W-1:0] cap_col_q;

  logic             busy_q, busy_d, done_q, done_d;
  logic             rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic             wr_data_q, wr_data_d;
  logic [1:0]       rd_sel_q, rd_sel_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [LOG_H-1:0] rd_row;

  logic [LOG_W-1:0] cw, cw_m, cw_p;
  logic [8:0]       win;
  logic             rule_next;

  assign c_q   = k_q[LOG_W-1:0];
  assign y_inc = y_q + LOG_H'(1);

  // Apply the pending read capture before any shift so the freshest bit is used.
  always_comb begin
    top_e   = top_q;
    mid_e   = mid_q;
    bot_e   = bot_q;
    first_e = first_q;
    if (cap_en_q) begin
      case (cap_sel_q)
        SEL_TOP: top_e[cap_col_q] = rd_data;
        SEL_MID: begin
          mid_e[cap_col_q]   = rd_data;
          first_e[cap_col_q] = rd_data;
        end
        default: bot_e[cap_col_q] = rd_data;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    y_d     = y_q;
    top_d   = top_e;
    mid_d   = mid_e;
    bot_d   = bot_e;
    first_d = first_e;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRIME;
          k_d     = '0;
        end
      end
      ST_PRIME: begin
        if (&k_q[KW-1:LOG_W]) begin
          state_d = ST_COMPUTE;
          k_d     = '0;
          y_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_LOAD: begin
        if (k_q[LOG_W]) begin
          state_d = ST_COMPUTE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_COMPUTE: begin
        if (&c_q) begin
          if (&y_q) begin
            state_d = ST_DONE;
          end else begin
            top_d = mid_e;
            mid_d = bot_e;
            y_d   = y_inc;
            k_d   = '0;
            if (&y_inc) bot_d = first_e;
            else        state_d = ST_LOAD;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-cycle state, so the window uses the *_d rows.
  assign cw   = k_d[LOG_W-1:0];
  assign cw_m = cw - LOG_W'(1);
  assign cw_p = cw + LOG_W'(1);
  assign win  = {bot_d[cw_p], bot_d[cw], bot_d[cw_m],
                 mid_d[cw_p], mid_d[cw], mid_d[cw_m],
                 top_d[cw_p], top_d[cw], top_d[cw_m]};

  gol_cell_rule u_rule (
    .win_i  (win),
    .next_o (rule_next)
  );

  always_comb begin
    busy_d    = (state_d == ST_PRIME) | (state_d == ST_LOAD) | (state_d == ST_COMPUTE);
    done_d    = (state_d == ST_DONE);
    rd_en_d   = 1'b0;
    rd_sel_d  = SEL_TOP;
    rd_row    = '0;
    rd_addr_d = '0;
    if (state_d == ST_PRIME && !(&k_d[KW-1:LOG_W])) begin
      rd_en_d  = 1'b1;
      rd_sel_d = k_d[KW-1:LOG_W];
      case (k_d[KW-1:LOG_W])
        SEL_TOP: rd_row = '1;
        SEL_MID: rd_row = '0;
        default: rd_row = LOG_H'(1);
      endcase
      rd_addr_d = {rd_row, cw};
    end else if (state_d == ST_LOAD && !k_d[LOG_W]) begin
      rd_en_d   = 1'b1;
      rd_sel_d  = SEL_BOT;
      rd_row    = y_d + LOG_H'(1);
      rd_addr_d = {rd_row, cw};
    end
    wr_en_d   = (state_d == ST_COMPUTE);
    wr_addr_d = wr_en_d ? {y_d, cw} : '0;
    wr_data_d = wr_en_d & rule_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      y_q       <= '0;
      top_q     <= '0;
      mid_q     <= '0;
      bot_q     <= '0;
      first_q   <= '0;
      cap_en_q  <= 1'b0;
      cap_sel_q <= SEL_TOP;
      cap_col_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_sel_q  <= SEL_TOP;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      y_q       <= y_d;
      top_q     <= top_d;
      mid_q     <= mid_d;
      bot_q     <= bot_d;
      first_q   <= first_d;
      cap_en_q  <= rd_en_q;
      cap_sel_q <= rd_sel_q;
      cap_col_q <= rd_addr_q[LOG_W-1:0];
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_sel_q  <= rd_sel_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_gol_stream_engine.sv
// Bench for gol_stream_engine: table vectors, random boards, glider run and
// start/reset corner cases, all checked against a direct Life model.
module tb_gol_stream_engine;
  import gol_pkg::*;

  localparam int LW = GOL_LOG_W;
  localparam int LH = GOL_LOG_H;
  localparam int W  = 1 << LW;
  localparam int H  = 1 << LH;
  localparam int N  = W * H;
  localparam int BUSY_LEN = 3*W + 1 + H*W + (H-2)*(W+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, rd_en, wr_en, wr_data;
  logic          rd_data = 1'b0;
  logic [LW+LH-1:0] rd_addr, wr_addr;

  bit cur[N];
  bit nxt[N];
  bit exp_nxt[N];
  bit gl0[N];

  int n_vec = 0;
  int n_err = 0;
  int g_busy, g_wr, g_ord, g_done, g_ov, g_post;

  typedef struct packed {
    logic           fill;
    logic [1:0]     n_in;
    logic [2:0][7:0] ix;
    logic [2:0][7:0] iy;
    logic [1:0]     n_out;
    logic [2:0][7:0] ox;
    logic [2:0][7:0] oy;
  } vec_t;

  vec_t vecs[5];

  gol_stream_engine #(.LOG_W(LW), .LOG_H(LH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  // Current-state array with 1-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= cur[rd_addr];
  end

  function automatic int idx(input int x, input int y);
    return ((y % H + H) % H) * W + ((x % W + W) % W);
  endfunction

  function automatic void model_step();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) n += int'(cur[idx(x+dx, y+dy)]);
        exp_nxt[idx(x, y)] = (n == 3) || (cur[idx(x, y)] && n == 2);
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_board(input string name);
    int d;
    d = 0;
    for (int i = 0; i < N; i++) if (nxt[i] != exp_nxt[i]) d++;
    check(name, d, 0);
  endtask

  task automatic rand_board(input int pct);
    for (int i = 0; i < N; i++) cur[i] = ($urandom_range(99) < pct);
  endtask

  // One generation; optionally pulses start while writes are in progress.
  task automatic run_gen(input string name, input int pulse_cyc);
    int exp_addr, done_at;
    bit pulsed;
    g_busy = 0; g_wr = 0; g_ord = 0; g_done = 0; g_ov = 0; g_post = 0;
    exp_addr = 0; done_at = -1; pulsed = 1'b0;
    model_step();
    for (int i = 0; i < N; i++) nxt[i] = ~exp_nxt[i];
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < BUSY_LEN + 200; cyc++) begin
      if (busy) g_busy++;
      if (wr_en) begin
        if (int'(wr_addr) != exp_addr) g_ord++;
        nxt[wr_addr] = wr_data;
        exp_addr++;
        g_wr++;
      end
      if (rd_en && wr_en) g_ov++;
      if (done) begin
        g_done++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && cyc > done_at && (busy || done || rd_en || wr_en)) g_post++;
      if (done_at >= 0 && cyc >= done_at + 10) break;
      start = 1'b0;
      if (pulse_cyc > 0 && !pulsed && cyc >= pulse_cyc && wr_en) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, " done_seen"}, int'(done_at >= 0), 1);
    check({name, " busy_len"}, g_busy, BUSY_LEN);
    check({name, " wr_count"}, g_wr, N);
    check({name, " wr_order_err"}, g_ord, 0);
    check({name, " done_cycles"}, g_done, 1);
    check({name, " rd_wr_overlap"}, g_ov, 0);
    check({name, " activity_after_done"}, g_post, 0);
    check_board({name, " board"});
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " busy"}, int'(busy), 0);
    check({name, " done"}, int'(done), 0);
    check({name, " rd_en"}, int'(rd_en), 0);
    check({name, " wr_en"}, int'(wr_en), 0);
    check({name, " rd_addr"}, int'(rd_addr), 0);
    check({name, " wr_addr"}, int'(wr_addr), 0);
    check({name, " wr_data"}, int'(wr_data), 0);
  endtask

  initial begin
    int live, cnt, d;

    vecs[0] = '{fill: 1'b0, n_in: 2'd3, ix: {8'd12, 8'd11, 8'd10}, iy: {8'd5, 8'd5, 8'd5},
                n_out: 2'd3, ox: {8'd11, 8'd11, 8'd11}, oy: {8'd6, 8'd5, 8'd4}};
    vecs[1] = '{fill: 1'b0, n_in: 2'd3, ix: {8'd1, 8'd0, 8'd63}, iy: {8'd31, 8'd31, 8'd31},
                n_out: 2'd3, ox: {8'd0, 8'd0, 8'd0}, oy: {8'd0, 8'd31, 8'd30}};
    vecs[2] = '{fill: 1'b1, n_in: 2'd0, ix: '0, iy: '0, n_out: 2'd0, ox: '0, oy: '0};
    vecs[3] = '{fill: 1'b0, n_in: 2'd0, ix: '0, iy: '0, n_out: 2'd0, ox: '0, oy: '0};
    vecs[4] = '{fill: 1'b0, n_in: 2'd1, ix: {8'd0, 8'd0, 8'd20}, iy: {8'd0, 8'd0, 8'd20},
                n_out: 2'd0, ox: '0, oy: '0};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < N; i++) cur[i] = vecs[v].fill;
      for (int j = 0; j < int'(vecs[v].n_in); j++)
        cur[idx(int'(vecs[v].ix[j]), int'(vecs[v].iy[j]))] = 1'b1;
      run_gen($sformatf("vec%0d", v), 0);
      live = 0;
      for (int i = 0; i < N; i++) live += int'(nxt[i]);
      check($sformatf("vec%0d live_count", v), live, int'(vecs[v].n_out));
      for (int j = 0; j < int'(vecs[v].n_out); j++)
        check($sformatf("vec%0d cell(%0d,%0d)", v, vecs[v].ox[j], vecs[v].oy[j]),
              int'(nxt[idx(int'(vecs[v].ox[j]), int'(vecs[v].oy[j]))]), 1);
    end

    for (int r = 0; r < 2; r++) begin
      rand_board(25 + 15 * r);
      run_gen($sformatf("rand%0d", r), 0);
    end

    // Glider placed across both wrap edges; eight generations move it by (+2,+2).
    for (int i = 0; i < N; i++) cur[i] = 1'b0;
    cur[idx(62, 29)] = 1'b1;
    cur[idx(63, 30)] = 1'b1;
    cur[idx(61, 31)] = 1'b1;
    cur[idx(62, 31)] = 1'b1;
    cur[idx(63, 31)] = 1'b1;
    for (int i = 0; i < N; i++) gl0[i] = cur[i];
    for (int g = 0; g < 8; g++) begin
      run_gen($sformatf("glider_gen%0d", g), 0);
      for (int i = 0; i < N; i++) cur[i] = nxt[i];
    end
    d = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (cur[idx(x + 2, y + 2)] != gl0[idx(x, y)]) d++;
    check("glider_offset_diff", d, 0);

    rand_board(30);
    run_gen("start_in_compute", 1500);

    // Reset in the middle of a LOAD phase.
    rand_board(35);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < BUSY_LEN; cyc++) begin
      if (wr_en) cnt++;
      if (cnt >= 2 * W && rd_en) break;
      @(negedge clk);
    end
    check("load_reached", int'(cnt >= 2 * W && rd_en && !wr_en), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");
    reset = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (wr_en || rd_en || busy || done) cnt++;
    end
    check("quiet_after_reset", cnt, 0);
    run_gen("post_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gol_stream_engine.md
# gol_stream_engine

Next-state engine for the 64x32 toroidal Game of Life board. It replaces the neighbour-by-neighbour update loop with a three-row sliding window. The engine reads the current board through a 1-cycle-latency read port and emits exactly one next-state write per cell, in raster order, into the next-state array. The controller starts it from its idle loop. When it receives `done`, the controller runs the existing copy step, so the display never sees a partially updated board.

## Interface
- `LOG_W`, default 6, log2 of board width (W = 64)
- `LOG_H`, default 5, log2 of board height (H = 32)
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `busy`  out  1  high in PRIME, COMPUTE, LOAD
- `done`  out  1  one-cycle pulse when the last cell has been written
- `rd_en`  out  1  read request to the current-state array
- `rd_addr`  out  LOG_W+LOG_H  cell index, y*W + x
- `rd_data`  in  1  cell value; valid the cycle after `rd_en`
- `wr_en`  out  1  write strobe to the next-state array
- `wr_addr`  out  LOG_W+LOG_H  cell index, y*W + x
- `wr_data`  out  1  next-state value

## Operation
- Row registers, W bits each: `row_top`, `row_mid`, `row_bot`, `row_first` (copy of row 0). A row counter `y` and a column counter `c` drive the window.
- **IDLE**
  - All outputs are 0.
  - `start`=1 moves to PRIME.
- **PRIME**
  - Issues 3W consecutive reads: row H-1 into `row_top`, row 0 into `row_mid` and `row_first`, then row 1 into `row_bot`.
  - One drain cycle follows to capture the last `rd_data`.
  - Then y=0, c=0, and the state moves to COMPUTE.
- **COMPUTE**
  - One cell per cycle. `wr_en`=1, `wr_addr`=y*W+c.
  - Window columns are (c-1) mod W, c, (c+1) mod W, taken from top/mid/bot.
  - n = count of the 8 neighbours, 4 bits.
  - `wr_data` = (n==3) | (centre & n==2).
  - On c = W-1:
    - If y = H-1: move to DONE.
    - Otherwise shift `row_top`←`row_mid` and `row_mid`←`row_bot`, then set y←y+1 and c←0.
    - If the new y+1 = H-1: continue with LOAD of row H-1.
    - If the new y+1 = H (wrap): set `row_bot`←`row_first` in the same edge and stay in COMPUTE with no reads.
    - Otherwise: LOAD row y+1.
- **LOAD**
  - Issues W reads of the needed row, with `rd_addr`=row*W+k for k=0..W-1.
  - One drain cycle follows.
  - Fills `row_bot`, then returns to COMPUTE with c=0.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- **Read capture:** `rd_data` is written to the buffer bit selected by the address issued the previous cycle (registered index and target row).
- **Wrap-around:** every row index is taken mod H and every column index mod W. Masking is by width truncation; no comparators are used.
- **Boundary rules:**
  - `start` outside IDLE is ignored. The engine does not queue it or restart.
  - `reset` in any state returns to IDLE the next edge. `wr_en`, `rd_en`, `done` and `busy` are 0 from that edge, and no further writes are issued.
  - `rd_en` and `wr_en` are never high in the same cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `wr_en`=0, `rd_addr`=0, `wr_addr`=0, `wr_data`=0.
- All outputs are registered.
- PRIME takes 3W+1 cycles; COMPUTE takes H*W cycles in total; LOAD runs H-2 times at W+1 cycles each.
- `busy` lasts 3W+1 + H*W + (H-2)(W+1) = 4191 cycles at the defaults, followed by a 1-cycle `done`.
- The first PRIME read occurs the cycle after `start` is sampled.
- Writes are strictly in ascending `wr_addr` order, 0..2047, each exactly once.

## Structure
- Shared package `gol_pkg` holds:
  - `LOG_W` and `LOG_H` defaults;
  - the state encoding (IDLE, PRIME, LOAD, COMPUTE, DONE);
  - the next-state rule function, shared with any other update path.
- Sub-module `gol_cell_rule` is combinational: 9 inputs (3x3 window) to 1 output. It is instantiated once.
- The engine must work for any `LOG_W` ≥ 2 and `LOG_H` ≥ 2.

## Test plan
- Blinker: horizontal cells (10,5),(11,5),(12,5) -> next state is exactly (11,4),(11,5),(11,6) alive; all other writes 0.
- All-ones board -> 2048 writes, all `wr_data`=0. All-zeros board -> all 0. Check `busy` length is 4191 and `done` is a 1-cycle pulse.
- Toroidal wrap: live cells (63,31),(0,31),(1,31) -> alive at (0,30),(0,31),(0,0); verifies both row and column wrap and the `row_first` reuse path.
- Glider run 128 generations with an external copy model -> pattern returns to its start offset (+32,+32 mod W,H); compare every generation against a golden model.
- `start` pulsed during COMPUTE -> no restart, write count stays 2048, a single `done`.
- `reset` asserted mid-LOAD -> next cycle all outputs are 0 and there are no writes; a following `start` runs a full correct generation.
